wire_alu_bank: RTL and testbench

Parametrised, multi-channel successor to the single wire-in adder in the FrontPanel "First" bring-up design. It sits behind okWireIn / okTriggerIn / okWireOut / okTriggerOut endpoints in the okClk domain. Each channel captures operands and a mode on a start trigger, then runs a small FSM to compute ADD, SUB, ACCUMULATE or CLEAR. It returns the result, an overflow flag, a done pulse and an operation count. Optional unsigned saturation is available.

---
 rtl/wire_alu_bank.sv | 121 ++++++++++++
 tb/tb_wire_alu_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wire_alu_bank.sv
// Multi-channel operand capture + ALU bank behind FrontPanel wire/trigger endpoints.
// Each channel runs its own IDLE -> CAPT -> EXEC sequence started by a trigger pulse.
//
//  state  | meaning
//  -------+----------------------------------------------------------
//  S_IDLE | waiting for start; operands and mode captured on start
//  S_CAPT | compute (WIDTH+1)-bit intermediate from captured operands
//  S_EXEC | register result/ovf, update accumulator, pulse done
module wire_alu_bank #(
  parameter int NCH      = 2,
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic                   okClk,
  input  logic                   reset,
  input  logic [NCH*WIDTH-1:0]   op_a,
  input  logic [NCH*WIDTH-1:0]   op_b,
  input  logic [NCH*2-1:0]       mode,
  input  logic [NCH-1:0]         start,
  input  logic                   clear_missed,
  output logic [NCH*WIDTH-1:0]   result,
  output logic [NCH-1:0]         ovf,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         done,
  output logic [NCH-1:0]         missed,
  output logic [NCH*CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_EXEC} state_t;

  localparam logic [1:0] M_ADD = 2'd0;
  localparam logic [1:0] M_SUB = 2'd1;
  localparam logic [1:0] M_ACC = 2'd2;
  localparam logic [1:0] M_CLR = 2'd3;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cap_a, cap_b, acc_q, res_q, final_res;
    logic [1:0]         cap_mode;
    logic [WIDTH:0]     inter_q;
    logic               ovf_q, done_q, missed_q;
    logic [CNT_W-1:0]   cnt_q;

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_IDLE:  if (start[i]) state_d = S_CAPT;
        S_CAPT:  state_d = S_EXEC;
        S_EXEC:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Saturation direction follows the operation: borrow clamps low, carry clamps high.
    always_comb begin
      final_res = inter_q[WIDTH-1:0];
      if ((SATURATE != 0) && inter_q[WIDTH])
        final_res = (cap_mode == M_SUB) ? '0 : '1;
    end

    always_ff @(posedge okClk) begin
      if (reset) begin
        state_q  <= S_IDLE;
        cap_a    <= '0;
        cap_b    <= '0;
        cap_mode <= M_ADD;
        inter_q  <= '0;
        acc_q    <= '0;
        res_q    <= '0;
        ovf_q    <= 1'b0;
        done_q   <= 1'b0;
        missed_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        state_q <= state_d;
        done_q  <= 1'b0;

        if (start[i] && state_q != S_IDLE)
          missed_q <= 1'b1;
        else if (clear_missed)
          missed_q <= 1'b0;

        case (state_q)
          S_IDLE: begin
            if (start[i]) begin
              cap_a    <= op_a[i*WIDTH +: WIDTH];
              cap_b    <= op_b[i*WIDTH +: WIDTH];
              cap_mode <= mode[i*2 +: 2];
            end
          end
          S_CAPT: begin
            case (cap_mode)
              M_ADD:   inter_q <= {1'b0, cap_a} + {1'b0, cap_b};
              M_SUB:   inter_q <= {1'b0, cap_a} - {1'b0, cap_b};
              M_ACC:   inter_q <= {1'b0, acc_q} + {1'b0, cap_a};
              default: inter_q <= '0;
            endcase
          end
          S_EXEC: begin
            res_q  <= final_res;
            ovf_q  <= inter_q[WIDTH];
            done_q <= 1'b1;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cap_mode == M_ACC || cap_mode == M_CLR)
              acc_q <= final_res;
          end
          default: ;
        endcase
      end
    end

    assign result[i*WIDTH +: WIDTH]   = res_q;
    assign ovf[i]                     = ovf_q;
    assign busy[i]                    = (state_q != S_IDLE);
    assign done[i]                    = done_q;
    assign missed[i]                  = missed_q;
    assign op_count[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_wire_alu_bank.sv
// Directed bench for wire_alu_bank: a wrapping 16-bit-counter instance and a
// saturating 4-bit-counter instance driven by the same stimulus.
module tb_wire_alu_bank;
  localparam int W = 32;

  logic          okClk = 1'b0;
  logic          reset;
  logic [2*W-1:0] op_a, op_b;
  logic [3:0]    mode;
  logic [1:0]    start;
  logic          clear_missed;

  logic [2*W-1:0] res_w, res_s;
  logic [1:0]     ovf_w, ovf_s, busy_w, busy_s, done_w, done_s, miss_w, miss_s;
  logic [31:0]    cnt_w;
  logic [7:0]     cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 okClk = ~okClk;

  wire_alu_bank #(.NCH(2), .WIDTH(W), .CNT_W(16), .SATURATE(0)) dut_wrap (
    .okClk(okClk), .reset(reset), .op_a(op_a), .op_b(op_b), .mode(mode),
    .start(start), .clear_missed(clear_missed), .result(res_w), .ovf(ovf_w),
    .busy(busy_w), .done(done_w), .missed(miss_w), .op_count(cnt_w));

  wire_alu_bank #(.NCH(2), .WIDTH(W), .CNT_W(4), .SATURATE(1)) dut_sat (
    .okClk(okClk), .reset(reset), .op_a(op_a), .op_b(op_b), .mode(mode),
    .start(start), .clear_missed(clear_missed), .result(res_s), .ovf(ovf_s),
    .busy(busy_s), .done(done_s), .missed(miss_s), .op_count(cnt_s));

  typedef struct {
    logic [1:0]  m;
    logic [31:0] a, b;
    logic [31:0] res_w;
    logic        ovf_w;
    logic [31:0] res_s;
    logic        ovf_s;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input int ch, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    op_a[ch*W +: W] = a;
    op_b[ch*W +: W] = b;
    mode[ch*2 +: 2] = m;
    start[ch]       = 1'b1;
  endtask

  // Issues a start and returns in the cycle where done is expected.
  task automatic run_op(input int ch, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    start_op(ch, m, a, b);
    tick();
    start = '0;
    tick();
    tick();
  endtask

  initial begin
    vecs[0]  = '{2'd0, 32'd5,        32'd7, 32'd12,       1'b0, 32'd12,       1'b0};
    vecs[1]  = '{2'd0, 32'hFFFFFFFF, 32'd2, 32'd1,        1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[2]  = '{2'd1, 32'd3,        32'd5, 32'hFFFFFFFE, 1'b1, 32'd0,        1'b1};
    vecs[3]  = '{2'd1, 32'd9,        32'd4, 32'd5,        1'b0, 32'd5,        1'b0};
    vecs[4]  = '{2'd3, 32'd77,       32'd1, 32'd0,        1'b0, 32'd0,        1'b0};
    vecs[5]  = '{2'd2, 32'hFFFFFFF0, 32'd9, 32'hFFFFFFF0, 1'b0, 32'hFFFFFFF0, 1'b0};
    vecs[6]  = '{2'd2, 32'h20,       32'd0, 32'h10,       1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{2'd2, 32'd1,        32'd0, 32'h11,       1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{2'd0, 32'd0,        32'd0, 32'd0,        1'b0, 32'd0,        1'b0};
    vecs[9]  = '{2'd3, 32'd0,        32'd0, 32'd0,        1'b0, 32'd0,        1'b0};
    vecs[10] = '{2'd2, 32'd7,        32'd3, 32'd7,        1'b0, 32'd7,        1'b0};

    reset = 1'b1; op_a = '0; op_b = '0; mode = '0; start = '0; clear_missed = 1'b0;
    tick(); tick();
    check("rst_result", res_w, 64'd0);
    check("rst_flags", {ovf_w, busy_w, done_w, miss_w}, 64'd0);
    check("rst_count", cnt_w, 64'd0);
    reset = 1'b0;
    tick();

    // ch0 ADD 5+7 with latency/busy checks
    start_op(0, 2'd0, 32'd5, 32'd7);
    tick(); start = '0;
    check("t1_busy_t1", busy_w, 64'b01);
    tick();
    check("t1_busy_t2", busy_w, 64'b01);
    check("t1_done_early", done_w, 64'b00);
    tick();
    check("t1_done", done_w, 64'b01);
    check("t1_result", res_w[31:0], 64'd12);
    check("t1_ovf", ovf_w, 64'b00);
    check("t1_count", cnt_w[15:0], 64'd1);
    check("t1_ch1_idle", {res_w[63:32], cnt_w[31:16]}, 64'd0);
    tick();
    check("t1_done_one_cycle", {done_w, busy_w}, 64'd0);

    // table vectors on ch1, both overflow policies
    for (int v = 0; v < 11; v++) begin
      run_op(1, vecs[v].m, vecs[v].a, vecs[v].b);
      check($sformatf("vec%0d_done", v), {done_w, done_s}, 64'b1010);
      check($sformatf("vec%0d_res_wrap", v), {ovf_w[1], res_w[63:32]}, {vecs[v].ovf_w, vecs[v].res_w});
      check($sformatf("vec%0d_res_sat", v), {ovf_s[1], res_s[63:32]}, {vecs[v].ovf_s, vecs[v].res_s});
    end
    check("vec_counts", {cnt_w[31:16], 4'd0, cnt_s[7:4]}, {16'd11, 4'd0, 4'd11});
    check("vec_ch0_held", res_w[31:0], 64'd12);

    // accumulator sequence on ch0
    run_op(0, 2'd3, 32'd0, 32'd0);
    check("acc_clr", res_w[31:0], 64'd0);
    run_op(0, 2'd2, 32'd10, 32'd0);
    check("acc_1", res_w[31:0], 64'd10);
    run_op(0, 2'd2, 32'd10, 32'd0);
    check("acc_2", res_w[31:0], 64'd20);
    run_op(0, 2'd2, 32'd10, 32'd0);
    check("acc_3", res_w[31:0], 64'd30);
    run_op(0, 2'd0, 32'd1, 32'd1);
    check("acc_add", res_w[31:0], 64'd2);
    run_op(0, 2'd2, 32'd10, 32'd0);
    check("acc_4", res_w[31:0], 64'd40);

    // start while busy is ignored and flagged
    start_op(0, 2'd0, 32'd1, 32'd2);
    tick();
    start_op(0, 2'd0, 32'd100, 32'd100);
    tick(); start = '0;
    check("miss_set", {miss_w, miss_s}, 64'b0101);
    tick();
    check("miss_done", done_w, 64'b01);
    check("miss_result", res_w[31:0], 64'd3);
    tick();
    check("miss_no_second", {done_w, busy_w}, 64'd0);
    clear_missed = 1'b1;
    tick(); clear_missed = 1'b0;
    check("miss_cleared", {miss_w, miss_s}, 64'd0);
    run_op(0, 2'd0, 32'd4, 32'd4);
    check("b2b_done1", {done_w, res_w[31:0]}, {30'd0, 2'b01, 32'd8});
    run_op(0, 2'd1, 32'd4, 32'd1);
    check("b2b_done2", {done_w, res_w[31:0]}, {30'd0, 2'b01, 32'd3});
    check("b2b_no_miss", miss_w, 64'd0);

    // simultaneous starts on both channels
    start_op(0, 2'd0, 32'd1, 32'd2);
    start_op(1, 2'd1, 32'd9, 32'd4);
    tick(); start = '0;
    tick(); tick();
    check("both_done", done_w, 64'b11);
    check("both_results", res_w, {32'd5, 32'd3});

    // reset during ch0 EXEC aborts the operation
    start_op(0, 2'd0, 32'd50, 32'd50);
    tick(); start = '0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_flags", {ovf_w, busy_w, done_w, miss_w}, 64'd0);
    check("abort_result", res_w, 64'd0);
    check("abort_count", {cnt_w, 24'd0, cnt_s}, 64'd0);
    reset = 1'b0;
    tick();

    // counter wrap: 4-bit instance wraps after 16 ops
    for (int k = 0; k < 16; k++) run_op(0, 2'd0, k, 32'd1);
    check("wrap_count16", {cnt_w[15:0], 12'd0, cnt_s[3:0]}, {16'd16, 16'd0});
    check("wrap_last_res", res_w[31:0], 64'd16);
    run_op(0, 2'd0, 32'd0, 32'd0);
    check("wrap_count17", {cnt_w[15:0], 12'd0, cnt_s[3:0]}, {16'd17, 16'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
